// File: rtl/irq_ctrl.sv
// Platform interrupt controller: per-source sync, polarity, level/edge pending,
// masked MEI outputs, and a small register port with a registered acknowledge.
module irq_ctrl #(
    parameter int N_SRC = 6
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [N_SRC-1:0] i_SRC,
    input  logic             i_WE,
    input  logic             i_RE,
    input  logic [4:0]       i_ADDR,
    input  logic [31:0]      i_WDATA,
    output logic [31:0]      o_RDATA,
    output logic             o_ACK,
    output logic [5:0]       o_MEI,
    output logic             o_IRQ_ANY
);

    localparam logic [5:0] SRC_MASK = 6'((7'd1 << N_SRC) - 7'd1);

    localparam logic [4:0] ADDR_PENDING  = 5'h00;
    localparam logic [4:0] ADDR_ENABLE   = 5'h04;
    localparam logic [4:0] ADDR_EDGE     = 5'h08;
    localparam logic [4:0] ADDR_POLARITY = 5'h0C;
    localparam logic [4:0] ADDR_RAW      = 5'h10;

    logic [5:0]  sync1_q, sync1_d;
    logic [5:0]  sync2_q, sync2_d;
    logic [5:0]  act_prev_q, act_prev_d;
    logic [5:0]  pending_q, pending_d;
    logic [5:0]  enable_q, enable_d;
    logic [5:0]  edge_q, edge_d;
    logic [5:0]  pol_q, pol_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;

    logic [5:0]  src_ext;
    logic [5:0]  active;
    logic [5:0]  edge_set;
    logic [5:0]  w1c;
    logic [5:0]  wdata_m;

    // Only the low bits of the write data carry register contents.
    logic unused_wdata;
    assign unused_wdata = ^i_WDATA[31:6];

    always_comb begin
        src_ext = '0;
        src_ext[N_SRC-1:0] = i_SRC;
        wdata_m = i_WDATA[5:0] & SRC_MASK;

        sync1_d    = src_ext;
        sync2_d    = sync1_q;
        active     = sync2_q ^ pol_q;
        act_prev_d = active;
        edge_set   = active & ~act_prev_q;

        w1c = (i_WE && i_ADDR == ADDR_PENDING) ? wdata_m : '0;
        // Edge sources: a new edge wins over a same-cycle clear. Level sources follow active.
        pending_d = ((edge_set | (pending_q & ~w1c)) & edge_q) | (active & ~edge_q);

        enable_d = (i_WE && i_ADDR == ADDR_ENABLE)   ? wdata_m : enable_q;
        edge_d   = (i_WE && i_ADDR == ADDR_EDGE)     ? wdata_m : edge_q;
        pol_d    = (i_WE && i_ADDR == ADDR_POLARITY) ? wdata_m : pol_q;

        rdata_d = '0;
        if (i_RE && !i_WE) begin
            case (i_ADDR)
                ADDR_PENDING:  rdata_d = {26'd0, pending_q};
                ADDR_ENABLE:   rdata_d = {26'd0, enable_q};
                ADDR_EDGE:     rdata_d = {26'd0, edge_q};
                ADDR_POLARITY: rdata_d = {26'd0, pol_q};
                ADDR_RAW:      rdata_d = {26'd0, sync2_q};
                default:       rdata_d = '0;
            endcase
        end
        ack_d = i_WE | i_RE;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            act_prev_q <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            edge_q     <= '0;
            pol_q      <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            act_prev_q <= act_prev_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            edge_q     <= edge_d;
            pol_q      <= pol_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
        end
    end

    assign o_MEI     = pending_q & enable_q;
    assign o_IRQ_ANY = |o_MEI;
    assign o_RDATA   = rdata_q;
    assign o_ACK     = ack_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  src = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic [5:0]  mei;
    logic        irq_any;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.N_SRC(6)) dut (
        .i_CLK(clk), .i_RST(rst), .i_SRC(src), .i_WE(we), .i_RE(re),
        .i_ADDR(addr), .i_WDATA(wdata), .o_RDATA(rdata), .o_ACK(ack),
        .o_MEI(mei), .o_IRQ_ANY(irq_any)
    );

    always #5 clk = ~clk;

    // Behavioural model: what software should observe.
    logic [5:0]  m_pend, m_en, m_edge, m_pol, m_seen0, m_seen1, m_prev;
    logic        m_ack, m_rdv;
    logic [31:0] m_rdata;

    function automatic logic [31:0] reg_val(input logic [4:0] a);
        case (a)
            5'h00:   return {26'd0, m_pend};
            5'h04:   return {26'd0, m_en};
            5'h08:   return {26'd0, m_edge};
            5'h0C:   return {26'd0, m_pol};
            5'h10:   return {26'd0, m_seen1};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_edge = '0; m_pol = '0;
        m_seen0 = '0; m_seen1 = '0; m_prev = '0;
        m_ack = 1'b0; m_rdv = 1'b0; m_rdata = '0;
    endtask

    task automatic model_step();
        logic [5:0] act;
        act = m_seen1 ^ m_pol;
        m_ack = we | re;
        m_rdv = re & ~we;
        m_rdata = reg_val(addr);
        for (int k = 0; k < 6; k++) begin
            if (!m_edge[k])
                m_pend[k] = act[k];
            else if (act[k] && !m_prev[k])
                m_pend[k] = 1'b1;
            else if (we && addr == 5'h00 && wdata[k])
                m_pend[k] = 1'b0;
        end
        if (we) begin
            if (addr == 5'h04) m_en   = wdata[5:0];
            if (addr == 5'h08) m_edge = wdata[5:0];
            if (addr == 5'h0C) m_pol  = wdata[5:0];
        end
        m_prev  = act;
        m_seen1 = m_seen0;
        m_seen0 = src;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("mei", {26'd0, mei}, {26'd0, m_pend & m_en});
        chk("irq_any", {31'd0, irq_any}, {31'd0, |(m_pend & m_en)});
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        if (m_rdv) chk("rdata", rdata, m_rdata);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        cycle();
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string name);
        re = 1'b1; addr = a;
        cycle();
        re = 1'b0;
        chk(name, rdata, exp);
        chk({name, "_ack"}, {31'd0, ack}, 32'd1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        idle(3);
        rst = 1'b0;

        // Reset state and reads of every register
        chk("reset_mei", {26'd0, mei}, 32'd0);
        bus_read(5'h00, 32'd0, "rst_pending");
        bus_read(5'h04, 32'd0, "rst_enable");
        bus_read(5'h08, 32'd0, "rst_edge");
        bus_read(5'h0C, 32'd0, "rst_pol");
        bus_read(5'h10, 32'd0, "rst_raw");
        cycle();
        chk("ack_single", {31'd0, ack}, 32'd0);

        // Level, active-high, latency of three edges
        bus_write(5'h04, 32'h01);
        src[0] = 1'b1;
        idle(2);
        chk("lvl_lat2", {26'd0, mei}, 32'h00);
        cycle();
        chk("lvl_rise", {26'd0, mei}, 32'h01);
        src[0] = 1'b0;
        idle(3);
        chk("lvl_fall", {26'd0, mei}, 32'h00);
        src[0] = 1'b1;
        idle(3);
        bus_write(5'h00, 32'h01);
        chk("lvl_w1c_noeffect", {26'd0, mei}, 32'h01);
        src[0] = 1'b0;
        idle(4);

        // Edge, rising, held after the pulse and cleared by W1C
        bus_write(5'h08, 32'h04);
        bus_write(5'h04, 32'h04);
        src[2] = 1'b1;
        idle(2);
        src[2] = 1'b0;
        idle(4);
        bus_read(5'h00, 32'h04, "edge_held");
        chk("edge_mei", {26'd0, mei}, 32'h04);
        bus_write(5'h00, 32'h04);
        bus_read(5'h00, 32'h00, "edge_cleared");

        // Same-edge set and W1C on source 3: set wins
        bus_write(5'h08, 32'h0C);
        bus_write(5'h04, 32'h0C);
        src[3] = 1'b1;
        idle(2);
        bus_write(5'h00, 32'h08);
        bus_read(5'h00, 32'h08, "set_wins");
        src[3] = 1'b0;
        bus_write(5'h00, 32'h08);
        bus_read(5'h00, 32'h00, "w1c_after_set");

        // Polarity inversion in level mode, then masking
        bus_write(5'h08, 32'h00);
        bus_write(5'h0C, 32'h02);
        bus_write(5'h04, 32'h02);
        idle(3);
        chk("pol_mei", {26'd0, mei}, 32'h02);
        bus_write(5'h04, 32'h00);
        chk("mask_mei", {26'd0, mei}, 32'h00);
        bus_read(5'h00, 32'h02, "mask_pending");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int op;
            int asel;
            logic [4:0] ra;
            if ($urandom_range(0, 3) == 0) src = 6'($urandom);
            op = $urandom_range(0, 11);
            asel = $urandom_range(0, 6);
            ra = (asel < 5) ? 5'(asel * 4) : 5'($urandom_range(0, 31));
            addr = ra;
            wdata = $urandom;
            we = (op < 3 || op == 6);
            re = (op >= 3 && op <= 6);
            cycle();
            we = 1'b0;
            re = 1'b0;
        end

        // All sources pending, then async reset with an access in flight
        src = '0;
        bus_write(5'h08, 32'h00);
        bus_write(5'h0C, 32'h3F);
        bus_write(5'h04, 32'h3F);
        idle(3);
        bus_read(5'h00, 32'h3F, "all_pending");
        chk("all_mei", {26'd0, mei}, 32'h3F);
        re = 1'b1; addr = 5'h00;
        #2;
        rst = 1'b1;
        #1;
        chk("async_mei", {26'd0, mei}, 32'h00);
        chk("async_irq", {31'd0, irq_any}, 32'd0);
        model_reset();
        cycle();
        re = 1'b0;
        chk("inflight_ack", {31'd0, ack}, 32'd0);
        idle(2);
        rst = 1'b0;
        bus_read(5'h00, 32'd0, "post_pending");
        bus_read(5'h04, 32'd0, "post_enable");
        bus_read(5'h08, 32'd0, "post_edge");
        bus_read(5'h0C, 32'd0, "post_pol");
        bus_read(5'h10, 32'd0, "post_raw");
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
